// File: rtl/approx_err_monitor.sv
// approx_err_monitor: two-stage error statistics (count, sum, max of |approx - exact|) for an approximate adder.
// Define APPROX_ERR_BIAS_EN to add the saturating signed-error accumulator sum_signed_err.
module approx_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_a,
  input  logic [WIDTH-1:0]          in_b,
  input  logic [WIDTH:0]            approx_sum,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [WIDTH+CNT_W:0]      sum_abs_err,
`ifdef APPROX_ERR_BIAS_EN
  output logic signed [WIDTH+CNT_W+1:0] sum_signed_err,
`endif
  output logic [WIDTH:0]            max_abs_err
);
  localparam int SW = WIDTH + 1 + CNT_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;
  logic [CNT_W-1:0] n_lat, cnt_inc;
  logic [WIDTH:0] exact, abs_err, abs1;
  logic signed [WIDTH+1:0] err, err_neg;
  logic [SW:0] sum_ext;
  logic v1, accept, start_ok;
  always_comb begin
    exact = {1'b0, in_a} + {1'b0, in_b};
    err = $signed({1'b0, approx_sum}) - $signed({1'b0, exact});
    err_neg = -err;
    abs_err = err[WIDTH+1] ? err_neg[WIDTH:0] : err[WIDTH:0];
    accept = in_valid && state == RUN;
    start_ok = start && (state == IDLE || state == DONE);
    cnt_inc = sample_cnt + CNT_W'(1);
    sum_ext = {1'b0, sum_abs_err} + {{(CNT_W+1){1'b0}}, abs1};
    state_nx = start_ok ? (num_samples == '0 ? DRAIN : RUN)
             : (accept && cnt_inc == n_lat) ? DRAIN
             : (state == DRAIN && !v1) ? DONE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      n_lat <= '0;
      v1 <= 1'b0;
      abs1 <= '0;
      sample_cnt <= '0;
      err_cnt <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
    end else begin
      state <= state_nx;
      v1 <= accept;
      abs1 <= abs_err;
      if (start_ok) begin
        n_lat <= num_samples;
        sample_cnt <= '0;
        err_cnt <= '0;
        sum_abs_err <= '0;
        max_abs_err <= '0;
      end else begin
        if (accept) sample_cnt <= cnt_inc;
        if (v1) begin
          sum_abs_err <= sum_ext[SW] ? '1 : sum_ext[SW-1:0];
          if (abs1 != '0 && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
          if (abs1 > max_abs_err) max_abs_err <= abs1;
        end
      end
    end
  end
`ifdef APPROX_ERR_BIAS_EN
  localparam int SSW = WIDTH + 2 + CNT_W;
  logic signed [WIDTH+1:0] err1;
  logic [SSW:0] ssum_ext;
  always_comb ssum_ext = {sum_signed_err[SSW-1], sum_signed_err} + {{(CNT_W+1){err1[WIDTH+1]}}, err1};
  // a sign disagreement between the guard bit and the top bit means the add overflowed
  always_ff @(posedge clk) begin
    if (rst) begin
      err1 <= '0;
      sum_signed_err <= '0;
    end else begin
      err1 <= err;
      if (start_ok) sum_signed_err <= '0;
      else if (v1) sum_signed_err <= (ssum_ext[SSW] != ssum_ext[SSW-1])
        ? (ssum_ext[SSW] ? {1'b1, {(SSW-1){1'b0}}} : {1'b0, {(SSW-1){1'b1}}})
        : ssum_ext[SSW-1:0];
    end
  end
`endif
  assign in_ready = state == RUN;
  assign busy = state == RUN || state == DRAIN;
  assign done = state == DONE;
endmodule

// File: tb/tb_approx_err_monitor.sv
// tb_approx_err_monitor: directed runs with a result scoreboard popped on each rising done.
module tb_approx_err_monitor;
  localparam int W = 16;
  localparam int C = 32;
  typedef struct {longint sum; longint ec; longint mx; longint cnt; longint bias; bit lat;} exp_t;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, busy, done;
  logic [C-1:0] num_samples, sample_cnt, err_cnt;
  logic [W-1:0] in_a, in_b;
  logic [W:0] approx_sum, max_abs_err;
  logic [W+C:0] sum_abs_err;
`ifdef APPROX_ERR_BIAS_EN
  logic signed [W+C+1:0] sum_signed_err;
`endif
  int checks = 0, errors = 0, cyc = 0, acc_cyc = 0;
  bit done_q = 1'b0;
  exp_t exp_q[$];
  exp_t e;

  approx_err_monitor #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .approx_sum(approx_sum), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .sum_abs_err(sum_abs_err),
`ifdef APPROX_ERR_BIAS_EN
    .sum_signed_err(sum_signed_err),
`endif
    .max_abs_err(max_abs_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_run(longint s, longint ec, longint mx, longint cnt, longint bias, bit lat);
    exp_t x;
    x.sum = s; x.ec = ec; x.mx = mx; x.cnt = cnt; x.bias = bias; x.lat = lat;
    exp_q.push_back(x);
  endtask

  task automatic go(int n);
    @(negedge clk);
    start = 1'b1;
    num_samples = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic beat(int a, int b, int p);
    in_valid = 1'b1;
    in_a = W'(a);
    in_b = W'(b);
    approx_sum = (W+1)'(p);
    for (int i = 0; i < 20 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("ready_timeout", 0, 1);
    else acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic finish_run(longint cnt, longint s);
    for (int i = 0; i < 20 && !done; i++) @(negedge clk);
    if (!done) chk("done_timeout", 0, 1);
    in_valid = 1'b1;
    in_a = 16'h1234;
    in_b = 16'h4321;
    approx_sum = '0;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("stable_cnt", longint'(sample_cnt), cnt);
    chk("stable_sum", longint'(sum_abs_err), s);
    chk("stable_done", longint'(done), 1);
  endtask

  always @(negedge clk) begin
    if (done && !done_q) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sum_abs_err", longint'(sum_abs_err), e.sum);
        chk("err_cnt", longint'(err_cnt), e.ec);
        chk("max_abs_err", longint'(max_abs_err), e.mx);
        chk("sample_cnt", longint'(sample_cnt), e.cnt);
`ifdef APPROX_ERR_BIAS_EN
        chk("sum_signed_err", longint'(sum_signed_err), e.bias);
`endif
        if (e.lat) chk("done_latency", longint'(cyc - acc_cyc), 3);
      end
    end
    done_q = done;
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; num_samples = '0;
    in_a = '0; in_b = '0; approx_sum = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_sum", longint'(sum_abs_err), 0);
    chk("rst_max", longint'(max_abs_err), 0);
    rst = 1'b0;
    // basic three-beat run
    expect_run(3, 2, 2, 3, 1, 1);
    go(3); beat(1, 1, 2); beat(3, 1, 3); beat(0, 0, 2);
    finish_run(3, 3);
    // empty run
    expect_run(0, 0, 0, 0, 0, 0);
    go(0);
    finish_run(0, 0);
    // gapped valid with junk data on the idle cycle; max must not drop back
    expect_run(5, 1, 5, 2, 5, 1);
    go(2); beat(7, 8, 20);
    in_a = 16'd100; in_b = 16'd100; approx_sum = '0;
    @(negedge clk);
    beat(5, 5, 10);
    chk("drain_ready", longint'(in_ready), 0);
    chk("drain_busy", longint'(busy), 1);
    finish_run(2, 5);
    // largest exact sum against zero
    expect_run('h1FFFE, 1, 'h1FFFE, 1, -'h1FFFE, 1);
    go(1); beat('hFFFF, 'hFFFF, 0);
    finish_run(1, 'h1FFFE);
    // largest possible abs error
    expect_run('h1FFFF, 1, 'h1FFFF, 1, 'h1FFFF, 1);
    go(1); beat(0, 0, 'h1FFFF);
    finish_run(1, 'h1FFFF);
    // start while running is ignored
    expect_run(3, 1, 3, 2, 3, 1);
    go(2); beat(10, 0, 10);
    start = 1'b1; num_samples = '0;
    @(negedge clk);
    start = 1'b0;
    beat(0, 0, 3);
    finish_run(2, 3);
    // reset mid-run, then reset beating a simultaneous start
    go(4); beat(1, 1, 9);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_done", longint'(done), 0);
    chk("midrst_ready", longint'(in_ready), 0);
    chk("midrst_cnt", longint'(sample_cnt), 0);
    chk("midrst_sum", longint'(sum_abs_err), 0);
    chk("midrst_err", longint'(err_cnt), 0);
    start = 1'b1; num_samples = 4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_over_start_busy", longint'(busy), 0);
    repeat (3) @(negedge clk);
    chk("midrst_late_sum", longint'(sum_abs_err), 0);
    expect_run(1, 1, 1, 1, 1, 1);
    go(1); beat(2, 2, 5);
    finish_run(1, 1);
`ifdef APPROX_ERR_BIAS_EN
    expect_run(3, 2, 2, 2, -1, 1);
    go(2); beat(1, 1, 3); beat(1, 1, 0);
    finish_run(2, 3);
`endif
    repeat (3) @(negedge clk);
    chk("pending_results", longint'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
